note_sequencer: RTL and testbench

- Plays a programmed list of notes by driving the team's duration counter (limit, limit_we, enable, reset and limit_reached).
- Each table entry holds a pitch code and a duration. The sequencer loads the duration as the counter limit, presents the pitch while the counter runs, and advances when limit_reached rises.
- Sits between the control/keyboard logic and the tone generator. The counter is instantiated beside it at top level.

---
 rtl/note_seq_pkg.sv | 21 ++
 rtl/note_sequencer_table.sv | 26 ++
 rtl/note_sequencer.sv | 143 ++++++++++++++
 tb/tb_note_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/note_seq_pkg.sv
// Shared definitions for the note sequencer: FSM states and note-entry layout.
package note_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // A zero duration marks the end of the programmed sequence.
  localparam int END_DUR = 0;

  // Duration occupies the low bits of an entry; pitch sits directly above it.
  localparam int DUR_LSB = 0;

  function automatic int pitch_lsb(input int dur_w);
    return dur_w;
  endfunction

endpackage

// File: rtl/note_sequencer_table.sv
// Note table: register file with synchronous write and combinational read.
// A read of an address being written in the same cycle returns the old data.
module seq_table #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Table storage; deliberately not reset so programmed notes survive a reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/note_sequencer.sv
// Note sequencer: steps through the note table, programming the external
// duration counter for each note and presenting the pitch while it runs.
module note_sequencer
  import note_seq_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int PITCH_W = 8,
  parameter int DUR_W   = 24
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       loop,
  input  logic                       prog_we,
  input  logic [$clog2(DEPTH)-1:0]   prog_addr,
  input  logic [PITCH_W+DUR_W-1:0]   prog_data,
  output logic [31:0]                cnt_limit,
  output logic                       cnt_limit_we,
  output logic                       cnt_enable,
  output logic                       cnt_reset,
  input  logic                       cnt_limit_reached,
  output logic [PITCH_W-1:0]         note_code,
  output logic                       note_valid,
  output logic                       busy,
  output logic                       done
);

  localparam int AW        = $clog2(DEPTH);
  localparam int EW        = PITCH_W + DUR_W;
  localparam int PITCH_LSB = pitch_lsb(DUR_W);

  state_t             state, state_nx;
  logic [AW-1:0]      idx, idx_nx;
  logic [PITCH_W-1:0] code_r, code_nx;
  logic               stop_rst_r, stop_rst_nx;

  logic [EW-1:0]      rd_entry;
  logic [DUR_W-1:0]   rd_dur;
  logic [PITCH_W-1:0] rd_pitch;
  logic               dur_zero;
  logic               last_idx;
  logic               load_note;

  seq_table #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_table (
    .clk   (clk),
    .we    (prog_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (idx),
    .rdata (rd_entry)
  );

  assign rd_dur   = rd_entry[DUR_LSB +: DUR_W];
  assign rd_pitch = rd_entry[PITCH_LSB +: PITCH_W];
  assign dur_zero = (rd_dur == DUR_W'(END_DUR));
  assign last_idx = (idx == AW'(DEPTH - 1));

  // Next-state, index and latched-pitch logic; stop overrides everything.
  always_comb begin
    state_nx    = state;
    idx_nx      = idx;
    code_nx     = code_r;
    stop_rst_nx = 1'b0;
    if (stop && (state != IDLE)) begin
      state_nx    = IDLE;
      stop_rst_nx = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start && !stop) begin
            state_nx = LOAD;
            idx_nx   = '0;
          end else begin
            state_nx = IDLE;
          end
        end
        LOAD: begin
          if (!dur_zero) begin
            code_nx  = rd_pitch;
            state_nx = RUN;
          end else if (loop && (idx != '0)) begin
            idx_nx   = '0;
            state_nx = LOAD;
          end else begin
            state_nx = DONE;
          end
        end
        RUN: begin
          if (cnt_limit_reached) begin
            if (!last_idx) begin
              idx_nx   = idx + AW'(1);
              state_nx = LOAD;
            end else if (loop) begin
              idx_nx   = '0;
              state_nx = LOAD;
            end else begin
              state_nx = DONE;
            end
          end else begin
            state_nx = RUN;
          end
        end
        DONE: begin
          state_nx = IDLE;
        end
        default: begin
          state_nx = IDLE;
        end
      endcase
    end
  end

  // State register; reset also raises the counter reset for the reset cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      code_r     <= '0;
      stop_rst_r <= 1'b1;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      code_r     <= code_nx;
      stop_rst_r <= stop_rst_nx;
    end
  end

  // Outputs decode registered state only, so inputs never reach them combinationally.
  assign load_note    = (state == LOAD) && !dur_zero;
  assign cnt_limit_we = load_note;
  assign cnt_limit    = load_note ? 32'(rd_dur) : 32'd0;
  assign cnt_reset    = stop_rst_r | load_note;
  assign cnt_enable   = (state == RUN);
  assign note_valid   = (state == RUN);
  assign note_code    = (state == RUN) ? code_r : '0;
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer with a behavioural duration counter.
module tb_note_sequencer;

  localparam int DEPTH   = 16;
  localparam int PITCH_W = 8;
  localparam int DUR_W   = 24;
  localparam int AW      = 4;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic                     start = 1'b0;
  logic                     stop = 1'b0;
  logic                     loop = 1'b0;
  logic                     prog_we = 1'b0;
  logic [AW-1:0]            prog_addr = '0;
  logic [PITCH_W+DUR_W-1:0] prog_data = '0;
  logic [31:0]              cnt_limit;
  logic                     cnt_limit_we;
  logic                     cnt_enable;
  logic                     cnt_reset;
  logic                     cnt_limit_reached;
  logic [PITCH_W-1:0]       note_code;
  logic                     note_valid;
  logic                     busy;
  logic                     done;

  note_sequencer #(.DEPTH(DEPTH), .PITCH_W(PITCH_W), .DUR_W(DUR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .loop(loop),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .cnt_limit(cnt_limit), .cnt_limit_we(cnt_limit_we), .cnt_enable(cnt_enable),
    .cnt_reset(cnt_reset), .cnt_limit_reached(cnt_limit_reached),
    .note_code(note_code), .note_valid(note_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Duration counter model: enable is registered, counts 0..limit, then a registered flag.
  logic [31:0] m_limit = 32'd0;
  logic [31:0] m_count = 32'd0;
  logic        m_en    = 1'b0;
  logic        m_flag  = 1'b0;
  assign cnt_limit_reached = m_flag;

  always @(posedge clk) begin
    if (cnt_limit_we) m_limit <= cnt_limit;
    if (cnt_reset) begin
      m_count <= 32'd0;
      m_en    <= 1'b0;
      m_flag  <= 1'b0;
    end else begin
      m_en <= cnt_enable;
      if (m_en) begin
        if (m_count == m_limit) m_flag <= 1'b1;
        else begin
          m_count <= m_count + 32'd1;
          m_flag  <= 1'b0;
        end
      end else begin
        m_flag <= 1'b0;
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: kind 0 = a completed note (code, cycles valid), kind 1 = done pulse.
  typedef struct {
    bit         kind;
    logic [7:0] code;
    int         len;
  } ev_t;
  ev_t sbq[$];

  task automatic exp_note(input logic [7:0] code, input int len);
    ev_t e;
    e.kind = 1'b0; e.code = code; e.len = len;
    sbq.push_back(e);
  endtask

  task automatic exp_done();
    ev_t e;
    e.kind = 1'b1; e.code = 8'h00; e.len = 0;
    sbq.push_back(e);
  endtask

  task automatic sb_pop(input bit kind, input logic [7:0] code, input int len);
    ev_t e;
    if (sbq.size() == 0) begin
      check("sb_unexpected_event", {31'd0, kind}, 32'hFFFF_FFFF);
    end else begin
      e = sbq.pop_front();
      check("ev_kind", {31'd0, kind}, {31'd0, e.kind});
      if (!e.kind) begin
        check("note_code", {24'd0, code}, {24'd0, e.code});
        check("note_len", 32'(len), 32'(e.len));
      end
    end
  endtask

  // Monitor: measures each note_valid run and reports done pulses.
  int         nstart = 0;
  int         run_len = 0;
  logic [7:0] run_code = 8'h00;
  logic       prev_valid = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (note_valid) begin
        if (!prev_valid) begin
          run_len  = 1;
          run_code = note_code;
          nstart++;
        end else begin
          run_len++;
          check("code_steady", {24'd0, note_code}, {24'd0, run_code});
        end
      end else if (prev_valid) begin
        sb_pop(1'b0, run_code, run_len);
      end
      if (done) sb_pop(1'b1, 8'h00, 0);
      prev_valid = note_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prog(input int addr, input logic [7:0] pitch, input int dur);
    prog_we   = 1'b1;
    prog_addr = AW'(addr);
    prog_data = {pitch, DUR_W'(dur)};
    tick();
    prog_we   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (busy && n < max) begin
      tick();
      n++;
    end
    check("idle_reached", {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_nstart(input int target, input int max);
    int n = 0;
    while (nstart < target && n < max) begin
      tick();
      n++;
    end
    check("note_start_reached", 32'(nstart >= target), 32'd1);
  endtask

  task automatic sb_empty(input string name);
    tick();
    tick();
    check(name, 32'(sbq.size()), 32'd0);
  endtask

  task automatic prog_basic();
    prog(0, 8'h3C, 5);
    prog(1, 8'h40, 2);
    prog(2, 8'h00, 0);
  endtask

  initial begin
    int base;
    // Reset state
    tick();
    tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_note_valid", {31'd0, note_valid}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_cnt_enable", {31'd0, cnt_enable}, 32'd0);
    check("rst_cnt_limit_we", {31'd0, cnt_limit_we}, 32'd0);
    check("rst_cnt_limit", cnt_limit, 32'd0);
    check("rst_note_code", {24'd0, note_code}, 32'd0);
    check("rst_cnt_reset", {31'd0, cnt_reset}, 32'd1);
    reset = 1'b0;
    tick();
    check("rst_cnt_reset_release", {31'd0, cnt_reset}, 32'd0);

    // Basic playback
    prog_basic();
    loop = 1'b0;
    exp_note(8'h3C, 8); exp_note(8'h40, 5); exp_done();
    pulse_start();
    check("load_limit_we", {31'd0, cnt_limit_we}, 32'd1);
    check("load_limit", cnt_limit, 32'd5);
    check("load_cnt_reset", {31'd0, cnt_reset}, 32'd1);
    wait_idle(100);
    sb_empty("sb_basic");

    // Loop; dropping loop during the third 0x3C ends after the following 0x40
    loop = 1'b1;
    base = nstart;
    exp_note(8'h3C, 8); exp_note(8'h40, 5);
    exp_note(8'h3C, 8); exp_note(8'h40, 5);
    exp_note(8'h3C, 8); exp_note(8'h40, 5); exp_done();
    pulse_start();
    wait_nstart(base + 5, 200);
    loop = 1'b0;
    wait_idle(100);
    sb_empty("sb_loop");

    // Empty table: LOAD then DONE, no note
    prog(0, 8'hAA, 0);
    loop = 1'b1;
    exp_done();
    pulse_start();
    check("empty_busy", {31'd0, busy}, 32'd1);
    check("empty_limit_we", {31'd0, cnt_limit_we}, 32'd0);
    tick();
    check("empty_done", {31'd0, done}, 32'd1);
    tick();
    check("empty_idle", {31'd0, busy}, 32'd0);
    loop = 1'b0;
    sb_empty("sb_empty_table");

    // Wrap without loop: 16 notes then done
    for (int i = 0; i < DEPTH; i++) prog(i, 8'h10 + 8'(i), 1);
    for (int i = 0; i < DEPTH; i++) exp_note(8'h10 + 8'(i), 4);
    exp_done();
    pulse_start();
    wait_idle(200);
    sb_empty("sb_wrap");

    // Wrap with loop: index returns to 0; drop loop during the second pass
    loop = 1'b1;
    base = nstart;
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < DEPTH; i++) exp_note(8'h10 + 8'(i), 4);
    exp_done();
    pulse_start();
    wait_nstart(base + 17, 200);
    loop = 1'b0;
    wait_idle(200);
    sb_empty("sb_wrap_loop");

    // Stop in the third RUN cycle
    prog_basic();
    exp_note(8'h3C, 3);
    pulse_start();
    tick();
    tick();
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_cnt_reset", {31'd0, cnt_reset}, 32'd1);
    check("stop_busy", {31'd0, busy}, 32'd0);
    check("stop_note_valid", {31'd0, note_valid}, 32'd0);
    tick();
    check("stop_cnt_reset_once", {31'd0, cnt_reset}, 32'd0);
    sb_empty("sb_stop");

    // Stop and start together in IDLE: stop wins
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check("stop_beats_start", {31'd0, busy}, 32'd0);

    // Reset in the second RUN cycle of entry 1, then replay from entry 0
    exp_note(8'h3C, 8); exp_note(8'h40, 2);
    pulse_start();
    for (int i = 0; i < 11; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_note_valid", {31'd0, note_valid}, 32'd0);
    check("mid_rst_cnt_enable", {31'd0, cnt_enable}, 32'd0);
    check("mid_rst_note_code", {24'd0, note_code}, 32'd0);
    check("mid_rst_cnt_reset", {31'd0, cnt_reset}, 32'd1);
    tick();
    exp_note(8'h3C, 8); exp_note(8'h40, 5); exp_done();
    pulse_start();
    wait_idle(100);
    sb_empty("sb_reset_replay");

    // Overwrite entry 1 while it plays, with an ignored start while busy
    loop = 1'b1;
    base = nstart;
    exp_note(8'h3C, 8); exp_note(8'h40, 5); exp_note(8'h3C, 8); exp_note(8'h55, 6); exp_done();
    pulse_start();
    wait_nstart(base + 2, 100);
    prog_we   = 1'b1;
    prog_addr = AW'(1);
    prog_data = {8'h55, DUR_W'(3)};
    start     = 1'b1;
    tick();
    prog_we   = 1'b0;
    start     = 1'b0;
    wait_nstart(base + 3, 100);
    loop = 1'b0;
    wait_idle(100);
    sb_empty("sb_write_play");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
